seven_seg_mux_driver: RTL and testbench

//  Time-multiplexed N-digit BCD seven-segment driver for the clock display.

---
 rtl/seven_seg_mux_driver_pkg.sv | 21 ++
 rtl/seven_seg_mux_driver_if.sv | 29 ++
 rtl/seven_seg_mux_driver_seg_decode_lut.sv | 27 ++
 rtl/seven_seg_mux_driver.sv | 129 ++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_mux_driver_pkg.sv
// Segment glyphs and widths for the seven-segment scan driver.
// Purely constants; no latency, no flow control.
package seven_seg_mux_driver_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  // Bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_ERR = 7'b1001001;

endpackage

// File: rtl/seven_seg_mux_driver_if.sv
// Display data in, segment/digit pins out; the driver is the slave side.
// Plain wires; no flow control (load_i is a one-cycle strobe).
interface seven_seg_mux_driver_if #(
  parameter int NUM_DIGITS = 6
);
  import seven_seg_mux_driver_pkg::*;

  logic [BCD_W*NUM_DIGITS-1:0] bcd_i;
  logic [NUM_DIGITS-1:0]       dp_i;
  logic                        load_i;
  logic                        lzs_i;
  logic                        blank_i;
  logic [3:0]                  bright_i;
  logic [SEG_W-1:0]            seg_o;
  logic                        dp_o;
  logic [NUM_DIGITS-1:0]       digit_sel_o;
  logic                        frame_o;

  modport master (
    output bcd_i, dp_i, load_i, lzs_i, blank_i, bright_i,
    input  seg_o, dp_o, digit_sel_o, frame_o
  );

  modport slave (
    input  bcd_i, dp_i, load_i, lzs_i, blank_i, bright_i,
    output seg_o, dp_o, digit_sel_o, frame_o
  );

endinterface

// File: rtl/seven_seg_mux_driver_seg_decode_lut.sv
// BCD digit to segment pattern; 10..15 map to the error glyph.
// Combinational, zero latency, no flow control.
module seg_decode_lut
  import seven_seg_mux_driver_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed BCD display scanner with frame-aligned commit, LZ blanking, dead-time, PWM brightness.
// One cycle from scan position to pins; never stalls (last load before a frame boundary wins).
module seven_seg_mux_driver
  import seven_seg_mux_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_LOG2 = 10,
  parameter int DEAD_CYCLES  = 4,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit DIG_ACT_LOW  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seven_seg_mux_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MSB = REFRESH_LOG2 - 1;
  localparam logic [REFRESH_LOG2-1:0] DEAD = REFRESH_LOG2'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_MSB:0]            slot_cnt;
  logic [IDX_W-1:0]            digit_idx;
  logic [BCD_W*NUM_DIGITS-1:0] pend_bcd, shadow_bcd;
  logic [NUM_DIGITS-1:0]       pend_dp, shadow_dp;
  logic                        pend_vld;
  logic [3:0]                  bright_q, bright_eff;
  logic                        slot_end, frame_end, commit;
  logic [NUM_DIGITS-1:0]       lz_mask;
  logic                        lz_seen;
  logic [BCD_W-1:0]            cur_bcd;
  logic [SEG_W-1:0]            cur_seg;
  logic                        digit_on;
  logic [SEG_W-1:0]            seg_q;
  logic                        dp_q;
  logic [NUM_DIGITS-1:0]       sel_q;
  logic                        frame_q;

  assign slot_end  = &slot_cnt;
  assign frame_end = slot_end && (digit_idx == LAST_IDX);
  assign commit    = frame_end && (pend_vld || bus.load_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_end)
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end
  end

  // Brightness is frozen for the whole slot so the PWM window cannot jitter mid-slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bright_q <= '0;
    else if (slot_cnt == '0)
      bright_q <= bus.bright_i;
  end

  assign bright_eff = (slot_cnt == '0) ? bus.bright_i : bright_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
    end else if (frame_end) begin
      if (bus.load_i) begin
        shadow_bcd <= bus.bcd_i;
        shadow_dp  <= bus.dp_i;
      end else if (pend_vld) begin
        shadow_bcd <= pend_bcd;
        shadow_dp  <= pend_dp;
      end
      pend_vld <= 1'b0;
    end else if (bus.load_i) begin
      pend_bcd <= bus.bcd_i;
      pend_dp  <= bus.dp_i;
      pend_vld <= 1'b1;
    end
  end

  // Walk down from the top digit; digit 0 is never blanked so "0" still shows.
  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (shadow_bcd[BCD_W*k +: BCD_W] != '0)
        lz_seen = 1'b1;
      lz_mask[k] = !lz_seen;
    end
  end

  assign cur_bcd = shadow_bcd[int'(digit_idx)*BCD_W +: BCD_W];

  seg_decode_lut u_decode (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  assign digit_on = !bus.blank_i
                 && (slot_cnt >= DEAD)
                 && (slot_cnt[CNT_MSB -: 4] <= bright_eff)
                 && !(bus.lzs_i && lz_mask[digit_idx]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q   <= '0;
      dp_q    <= 1'b0;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= digit_on ? cur_seg : '0;
      dp_q    <= digit_on && shadow_dp[digit_idx];
      sel_q   <= digit_on ? (NUM_DIGITS'(1) << digit_idx) : '0;
      frame_q <= commit;
    end
  end

  assign bus.seg_o       = seg_q ^ {SEG_W{SEG_ACT_LOW}};
  assign bus.dp_o        = dp_q ^ SEG_ACT_LOW;
  assign bus.digit_sel_o = sel_q ^ {NUM_DIGITS{DIG_ACT_LOW}};
  assign bus.frame_o     = frame_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Randomised + directed bench for seven_seg_mux_driver against a cycle-count reference model.
module tb_seven_seg_mux_driver;

  localparam int ND = 4;
  localparam int SLOT = 16;
  localparam int FRAME = SLOT * ND;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_mux_driver_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_mux_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_LOG2 (4),
    .DEAD_CYCLES  (DEAD),
    .SEG_ACT_LOW  (1'b0),
    .DIG_ACT_LOW  (1'b0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1001001, 7'b1001001,
    7'b1001001, 7'b1001001, 7'b1001001, 7'b1001001
  };

  int checks = 0;
  int errors = 0;

  // Reference state: what the display currently shows and what is queued.
  int         m_cyc;
  int         shown [ND];
  logic [3:0] shown_dp;
  int         pend [ND];
  logic [3:0] pend_dp;
  bit         pend_vld;
  int         m_bright;

  logic       c_lzs, c_blank;
  logic [3:0] c_bright;

  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_sel;
  logic       exp_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int k = 0; k < ND; k++) begin
      shown[k] = 0;
      pend[k]  = 0;
    end
    shown_dp = '0;
    pend_dp  = '0;
    pend_vld = 1'b0;
    m_bright = 0;
  endtask

  // Predict the pins after the coming edge from position-in-frame arithmetic.
  task automatic model_edge(input bit ld, input logic [15:0] b, input logic [3:0] d);
    int cnt, dig, lead;
    bit boundary, on;
    cnt = m_cyc % SLOT;
    dig = (m_cyc / SLOT) % ND;
    boundary = (m_cyc % FRAME) == FRAME - 1;
    if (cnt == 0) m_bright = int'(c_bright);
    lead = 0;
    for (int k = 0; k < ND; k++) if (shown[k] != 0) lead = k;
    on = !c_blank && cnt >= DEAD && cnt <= m_bright && !(c_lzs && dig > lead);
    exp_sel   = on ? 4'(1 << dig) : 4'd0;
    exp_seg   = on ? seg_tab[shown[dig]] : 7'd0;
    exp_dp    = on && shown_dp[dig];
    exp_frame = boundary && (ld || pend_vld);
    if (boundary) begin
      if (ld) begin
        for (int k = 0; k < ND; k++) shown[k] = int'(b[4*k +: 4]);
        shown_dp = d;
      end else if (pend_vld) begin
        shown = pend;
        shown_dp = pend_dp;
      end
      pend_vld = 1'b0;
    end else if (ld) begin
      for (int k = 0; k < ND; k++) pend[k] = int'(b[4*k +: 4]);
      pend_dp  = d;
      pend_vld = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic step(input bit ld, input logic [15:0] b, input logic [3:0] d);
    bus.load_i   = ld;
    bus.bcd_i    = ld ? b : 16'($urandom);
    bus.dp_i     = ld ? d : 4'($urandom);
    bus.lzs_i    = c_lzs;
    bus.blank_i  = c_blank;
    bus.bright_i = c_bright;
    model_edge(ld, b, d);
    @(posedge clk);
    #1;
    chk("seg", 32'(bus.seg_o), 32'(exp_seg));
    chk("dp", 32'(bus.dp_o), 32'(exp_dp));
    chk("sel", 32'(bus.digit_sel_o), 32'(exp_sel));
    chk("frame", 32'(bus.frame_o), 32'(exp_frame));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  // Advance until the next edge lands on the given position modulo m.
  task automatic align(input int m, input int pos);
    for (int i = 0; i < 2 * FRAME && (m_cyc % m) != pos; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_seg"}, 32'(bus.seg_o), 32'd0);
    chk({tag, "_dp"}, 32'(bus.dp_o), 32'd0);
    chk({tag, "_sel"}, 32'(bus.digit_sel_o), 32'd0);
    chk({tag, "_frame"}, 32'(bus.frame_o), 32'd0);
  endtask

  task automatic bright_count(input logic [3:0] b, input int want);
    int on_cnt;
    c_bright = b;
    align(SLOT, 0);
    on_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin
      step(1'b0, 16'h0, 4'h0);
      if (bus.digit_sel_o != '0) on_cnt++;
    end
    chk("on_count", 32'(on_cnt), 32'(want));
  endtask

  initial begin
    int frames;
    bus.load_i = 1'b0; bus.bcd_i = '0; bus.dp_i = '0;
    bus.lzs_i = 1'b0; bus.blank_i = 1'b0; bus.bright_i = 4'd15;
    c_lzs = 1'b0; c_blank = 1'b0; c_bright = 4'd15;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("rst_init");
    rst = 1'b0;
    run(20);

    // Plain number, every digit visible
    step(1'b1, 16'h1234, 4'b0100);
    run(2 * FRAME);

    // Leading zeros blanked, then shown again
    c_lzs = 1'b1;
    step(1'b1, 16'h0050, 4'b1111);
    run(2 * FRAME);
    c_lzs = 1'b0;
    run(FRAME);

    // Two loads inside one frame: last wins, one commit
    align(FRAME, 0);
    step(1'b1, 16'h1111, 4'h0);
    run(10);
    step(1'b1, 16'h2222, 4'h1);
    frames = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, 4'h0);
      if (bus.frame_o) frames++;
    end
    chk("frame_cnt", 32'(frames), 32'd1);
    run(FRAME);

    // Load on the boundary cycle bypasses the pending buffer
    align(FRAME, FRAME - 1);
    step(1'b1, 16'h00A0, 4'h2);
    chk("bypass_frame", 32'(bus.frame_o), 32'd1);
    run(FRAME + 8);

    // Reset in the middle of a lit slot
    align(SLOT, 8);
    chk("lit_before_rst", 32'(bus.digit_sel_o != '0), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_pins("rst_mid");
    @(posedge clk);
    #1;
    check_reset_pins("rst_hold");
    rst = 1'b0;
    model_reset();
    run(2 * SLOT);

    // Brightness window sizes
    bright_count(4'd0, 0);
    bright_count(4'd7, 6);
    bright_count(4'd15, 14);

    // Blank asserted mid-slot
    align(SLOT, 6);
    c_blank = 1'b1;
    run(SLOT + 3);
    c_blank = 1'b0;
    run(SLOT);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) c_lzs = ~c_lzs;
      if ($urandom_range(0, 49) == 0) c_blank = ~c_blank;
      if ($urandom_range(0, 29) == 0) c_bright = 4'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) v = v & 16'h00FF;
        step(1'b1, v, 4'($urandom));
      end else begin
        step(1'b0, 16'h0, 4'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
